// File: rtl/rsa_modexp_ctrl_if.sv
// Bus bundle for rsa_modexp_ctrl: job request/response plus the shared
// modular-multiplier start/done channel. The slave view is the sequencer itself.
interface rsa_modexp_ctrl_if #(
  parameter int KEY_WIDTH = 128,
  parameter int CNT_WIDTH = 16
) ();
  logic                 start;
  logic [KEY_WIDTH-1:0] base;
  logic [KEY_WIDTH-1:0] exp;
  logic [KEY_WIDTH-1:0] mod;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [KEY_WIDTH-1:0] result;
  logic [CNT_WIDTH-1:0] op_count;
  logic                 mm_start;
  logic [KEY_WIDTH-1:0] mm_a;
  logic [KEY_WIDTH-1:0] mm_b;
  logic [KEY_WIDTH-1:0] mm_n;
  logic                 mm_done;
  logic [KEY_WIDTH-1:0] mm_p;

  modport slave (
    input  start, base, exp, mod, mm_done, mm_p,
    output busy, done, err, result, op_count, mm_start, mm_a, mm_b, mm_n
  );

  modport master (
    output start, base, exp, mod, mm_done, mm_p,
    input  busy, done, err, result, op_count, mm_start, mm_a, mm_b, mm_n
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for r = base^exp mod n, driving
// one external modular multiplier over a start/done handshake.
module rsa_modexp_ctrl #(
  parameter int KEY_WIDTH = 128,
  parameter int CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  rsa_modexp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    MUL_ISSUE = 3'd2,
    MUL_WAIT  = 3'd3,
    SQR_ISSUE = 3'd4,
    SQR_WAIT  = 3'd5,
    SHIFT     = 3'd6,
    FINISH    = 3'd7
  } state_e;

  localparam logic [KEY_WIDTH-1:0] ONE     = KEY_WIDTH'(1);
  localparam logic [KEY_WIDTH-1:0] TWO     = KEY_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q;
  logic [KEY_WIDTH-1:0] acc_q;
  logic [KEY_WIDTH-1:0] sq_q;
  logic [KEY_WIDTH-1:0] e_sh_q;
  logic [KEY_WIDTH-1:0] n_q;
  logic [KEY_WIDTH-1:0] result_q;
  logic [KEY_WIDTH-1:0] mm_a_q;
  logic [KEY_WIDTH-1:0] mm_b_q;
  logic [KEY_WIDTH-1:0] mm_n_q;
  logic [CNT_WIDTH-1:0] op_count_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 mm_start_q;
  logic [KEY_WIDTH-1:0] e_shr_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  assign e_shr_d = {1'b0, e_sh_q[KEY_WIDTH-1:1]};

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.result   = result_q;
  assign bus.op_count = op_count_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  assign bus.mm_n     = mm_n_q;

  // Sequencer state, datapath registers and registered outputs.
  // Operands and mm_start are loaded on entry to an ISSUE state so they are
  // already stable in the cycle mm_start is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sq_q       <= '0;
      e_sh_q     <= '0;
      n_q        <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_n_q     <= '0;
      op_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.start) begin
            sq_q       <= bus.base;
            e_sh_q     <= bus.exp;
            n_q        <= bus.mod;
            acc_q      <= ONE;
            op_count_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= CHECK;
          end else begin
            state_q <= IDLE;
          end
        end

        CHECK: begin
          if (n_q < TWO) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= FINISH;
          end else if (e_sh_q == '0) begin
            result_q <= ONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= FINISH;
          end else if (e_sh_q[0]) begin
            mm_a_q     <= acc_q;
            mm_b_q     <= sq_q;
            mm_n_q     <= n_q;
            mm_start_q <= 1'b1;
            state_q    <= MUL_ISSUE;
          end else begin
            mm_a_q     <= sq_q;
            mm_b_q     <= sq_q;
            mm_n_q     <= n_q;
            mm_start_q <= 1'b1;
            state_q    <= SQR_ISSUE;
          end
        end

        MUL_ISSUE: begin
          mm_start_q <= 1'b0;
          op_count_q <= sat_inc(op_count_q);
          state_q    <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (bus.mm_done) begin
            acc_q <= bus.mm_p;
            // Last set bit: the trailing squaring would never be used.
            if (e_shr_d == '0) begin
              state_q <= SHIFT;
            end else begin
              mm_a_q     <= sq_q;
              mm_b_q     <= sq_q;
              mm_n_q     <= n_q;
              mm_start_q <= 1'b1;
              state_q    <= SQR_ISSUE;
            end
          end else begin
            state_q <= MUL_WAIT;
          end
        end

        SQR_ISSUE: begin
          mm_start_q <= 1'b0;
          op_count_q <= sat_inc(op_count_q);
          state_q    <= SQR_WAIT;
        end

        SQR_WAIT: begin
          if (bus.mm_done) begin
            sq_q    <= bus.mm_p;
            state_q <= SHIFT;
          end else begin
            state_q <= SQR_WAIT;
          end
        end

        SHIFT: begin
          e_sh_q <= e_shr_d;
          if (e_shr_d == '0) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= FINISH;
          end else if (e_shr_d[0]) begin
            mm_a_q     <= acc_q;
            mm_b_q     <= sq_q;
            mm_n_q     <= n_q;
            mm_start_q <= 1'b1;
            state_q    <= MUL_ISSUE;
          end else begin
            mm_a_q     <= sq_q;
            mm_b_q     <= sq_q;
            mm_n_q     <= n_q;
            mm_start_q <= 1'b1;
            state_q    <= SQR_ISSUE;
          end
        end

        FINISH: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          mm_start_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl: directed plan cases plus random jobs
// against a repeated-multiplication reference and a latency-configurable multiplier.
module tb_rsa_modexp_ctrl;
  localparam int KW = 128;
  localparam int CW = 16;

  typedef struct packed {
    logic [KW-1:0] res;
    logic          err;
    logic [CW-1:0] ops;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_modexp_ctrl_if #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) bus ();
  rsa_modexp_ctrl #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mm_lat = 3;
  bit   spur_en = 1'b0;

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input longint unsigned r, input bit e, input int ops);
    exp_t x;
    x.res = KW'(r);
    x.err = e;
    x.ops = CW'(ops);
    return x;
  endfunction

  // Reference: base multiplied in exp times; op count from popcount and bit length.
  function automatic exp_t model(input longint unsigned b, input longint unsigned e,
                                 input longint unsigned m);
    longint unsigned acc;
    int ones;
    int nbits;
    if (m < 2) return mk(0, 1'b1, 0);
    if (e == 0) return mk(1, 1'b0, 0);
    acc = 1;
    for (longint unsigned i = 0; i < e; i++) acc = (acc * b) % m;
    ones  = 0;
    nbits = 0;
    for (int k = 0; k < 64; k++) begin
      if (((e >> k) & 64'd1) != 0) begin
        ones++;
        nbits = k + 1;
      end
    end
    return mk(acc, 1'b0, ones + nbits - 1);
  endfunction

  // Multiplier model: fixed latency, optional stray done pulse right after each product.
  initial begin : mult_model
    logic [255:0] pa;
    logic [255:0] pb;
    logic [255:0] pn;
    logic [KW-1:0] prod;
    int cnt;
    bit pend;
    bit spur;
    bus.mm_done = 1'b0;
    bus.mm_p    = '0;
    pend = 1'b0;
    spur = 1'b0;
    cnt  = 0;
    prod = '0;
    forever begin
      @(negedge clk);
      bus.mm_done = 1'b0;
      if (spur) begin
        bus.mm_done = 1'b1;
        bus.mm_p    = KW'(12345);
        spur        = 1'b0;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          bus.mm_p    = prod;
          bus.mm_done = 1'b1;
          pend        = 1'b0;
          spur        = spur_en;
        end
      end
      if (bus.mm_start === 1'b1) begin
        pa   = {128'd0, bus.mm_a};
        pb   = {128'd0, bus.mm_b};
        pn   = {128'd0, bus.mm_n};
        prod = KW'((pa * pb) % pn);
        cnt  = mm_lat;
        pend = 1'b1;
      end
    end
  end

  // Monitor: pops an expectation on every done pulse.
  initial begin : monitor
    exp_t e;
    int ops_seen;
    ops_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ops_seen = 0;
      end else begin
        if (bus.mm_start === 1'b1) ops_seen++;
        if (bus.err === 1'b1 && bus.done !== 1'b1) check("err_without_done", bus.err, 0);
        if (bus.done === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", bus.done, 0);
          end else begin
            e = sb_q.pop_front();
            check("result", bus.result, e.res);
            check("err", bus.err, e.err);
            check("op_count", bus.op_count, e.ops);
            check("mm_start_pulses", ops_seen, e.ops);
            check("busy_at_done", bus.busy, 0);
          end
          ops_seen = 0;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({"done_within_bound_", name}, bus.done, 1);
  endtask

  task automatic drive(input longint unsigned b, input longint unsigned e, input longint unsigned m);
    bus.base = KW'(b);
    bus.exp  = KW'(e);
    bus.mod  = KW'(m);
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic run_job(input longint unsigned b, input longint unsigned e,
                         input longint unsigned m, input exp_t want, input string name);
    drive(b, e, m);
    bus.start = 1'b1;
    sb_q.push_back(want);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    longint unsigned b;
    longint unsigned e;
    longint unsigned m;
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    drive(0, 0, 0);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_mm_start", bus.mm_start, 0);
    check("rst_mm_n", bus.mm_n, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_job(4, 13, 497, mk(445, 1'b0, 6), "basic");
    run_job(65, 17, 3233, mk(2790, 1'b0, 6), "encrypt");
    run_job(2790, 2753, 3233, mk(65, 1'b0, 16), "decrypt");

    // exp == 0: done exactly two cycles after start, no multiplier traffic.
    drive(123, 0, 497);
    bus.start = 1'b1;
    sb_q.push_back(mk(1, 1'b0, 0));
    @(negedge clk);
    bus.start = 1'b0;
    check("exp0_busy_c1", bus.busy, 1);
    check("exp0_done_c1", bus.done, 0);
    @(negedge clk);
    check("exp0_done_c2", bus.done, 1);
    @(negedge clk);
    run_job(0, 5, 1, mk(0, 1'b1, 0), "mod1");

    // Stray mm_done after every product plus a start pulse mid-job.
    spur_en = 1'b1;
    drive(4, 13, 497);
    bus.start = 1'b1;
    sb_q.push_back(mk(445, 1'b0, 6));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    drive(7, 3, 11);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("spurious");
    @(negedge clk);
    spur_en = 1'b0;
    repeat (3) @(negedge clk);
    check("held_result", bus.result, 445);
    check("held_op_count", bus.op_count, 6);

    // Reset while the first multiply is outstanding.
    drive(4, 13, 497);
    bus.start = 1'b1;
    sb_q.push_back(mk(445, 1'b0, 6));
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.mm_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mm_start_seen", bus.mm_start, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_op_count", bus.op_count, 0);
    check("abort_mm_a", bus.mm_a, 0);
    check("abort_mm_start", bus.mm_start, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", bus.done, 0);
    run_job(4, 13, 497, mk(445, 1'b0, 6), "after_reset");

    // Back-to-back with start held high across FINISH.
    drive(4, 13, 497);
    bus.start = 1'b1;
    sb_q.push_back(mk(445, 1'b0, 6));
    @(negedge clk);
    drive(65, 17, 3233);
    sb_q.push_back(mk(2790, 1'b0, 6));
    wait_done("b2b_first");
    @(negedge clk);
    check("b2b_result_held", bus.result, 445);
    check("b2b_idle_busy", bus.busy, 0);
    @(negedge clk);
    check("b2b_second_busy", bus.busy, 1);
    bus.start = 1'b0;
    wait_done("b2b_second");
    @(negedge clk);

    // Random jobs with random multiplier latency.
    for (int j = 0; j < 30; j++) begin
      mm_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) m = longint'($urandom_range(0, 1));
      else m = longint'($urandom_range(2, 60000));
      b = (m < 2) ? 64'd0 : longint'($urandom) % m;
      e = longint'($urandom_range(0, 4095));
      run_job(b, e, m, model(b, e, m), "random");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Synthesizable sequencer that computes r = base^exp mod mod by right-to-left square-and-multiply.
- Owns no multiplier. It drives one shared external modular-multiplier unit (p = a*b mod n) over a start/done handshake, one operation at a time.
- Sits between the encrypter/decrypter front ends and the multiplier, replacing the behavioural exponentiation loop with a clocked, cycle-accountable engine.

Parameters:
- KEY_WIDTH, 128, width of base, exponent, modulus and result.
- CNT_WIDTH, 16, width of op_count (multiplier operations issued per job).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- base  in  KEY_WIDTH  message/ciphertext; caller guarantees base < mod.
- exp  in  KEY_WIDTH  exponent (e or d).
- mod  in  KEY_WIDTH  modulus n.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse, result valid.
- err  out  1  one-cycle pulse coincident with done when mod < 2.
- result  out  KEY_WIDTH  held until the next accepted start.
- op_count  out  CNT_WIDTH  multiplier ops issued in the current/last job.
- mm_start  out  1  one-cycle pulse, launches a multiplier op.
- mm_a, mm_b, mm_n  out  KEY_WIDTH  multiplier operands; stable from mm_start until mm_done.
- mm_done  in  1  one-cycle pulse, multiplier product valid.
- mm_p  in  KEY_WIDTH  product a*b mod n.

Behaviour:
- Reset (async): state IDLE; busy, done, err, mm_start = 0; result, op_count, mm_a/b/n = 0; internal acc, sq, e_sh cleared. Reset mid-job aborts immediately; any late mm_done afterwards is ignored.
- States: IDLE, CHECK, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, SHIFT, FINISH.
- IDLE: on start=1, latch sq<=base, e_sh<=exp, n<=mod, acc<=1, op_count<=0, then go to CHECK. start while not IDLE is ignored (no queueing).
- CHECK:
  - mod<2: result<=0, go to FINISH with err.
  - e_sh==0: result<=1, go to FINISH.
  - e_sh[0]=1: go to MUL_ISSUE.
  - e_sh[0]=0: go to SQR_ISSUE.
- MUL_ISSUE: mm_a=acc, mm_b=sq, mm_n=n; mm_start=1 for exactly this cycle; op_count++; go to MUL_WAIT.
- MUL_WAIT: on mm_done, acc<=mm_p. If e_sh>>1 == 0, go to SHIFT (final squaring skipped); else go to SQR_ISSUE.
- SQR_ISSUE: mm_a=mm_b=sq, mm_n=n; one-cycle mm_start; op_count++; go to SQR_WAIT.
- SQR_WAIT: on mm_done, sq<=mm_p, go to SHIFT.
- SHIFT: e_sh<=e_sh>>1.
  - New e_sh==0: result<=acc, go to FINISH.
  - Else: go to MUL_ISSUE if the new e_sh[0]=1, otherwise SQR_ISSUE.
- FINISH: done=1 (err=1 if mod<2) for one cycle; busy drops in the same cycle; return to IDLE.
- Latency with zero-wait multiplier: exp==0 or mod<2 gives done 2 cycles after start. Each op costs 2 cycles plus multiplier latency.
- Ops per job = popcount(exp) + (bit-length(exp) - 1).
- mm_done outside MUL_WAIT/SQR_WAIT is ignored. Inputs base/exp/mod may change while busy without effect.
- op_count saturates at all-ones.
- No arithmetic besides shift, compare and increment lives in this block.

Test Plan:
- Multiplier model with 3-cycle latency; base=4, exp=13, mod=497 -> result=445, op_count=6, one done pulse, err=0.
- Encrypt then decrypt: n=3233, e=17, m=65 -> 2790 (op_count=6); then base=2790, exp=2753 -> 65.
- exp=0, mod=497 -> result=1, done 2 cycles after start, op_count=0, no mm_start. mod=1 -> result=0, err=1 with done.
- start pulsed again while busy, plus a spurious mm_done in SHIFT -> both ignored, first job result unchanged, op_count unchanged.
- rst asserted during MUL_WAIT -> outputs go to 0 asynchronously; a late mm_done is ignored; a fresh job (4,13,497) gives 445.
- Back-to-back jobs with start held high across FINISH -> second job accepted in IDLE; result held between done and the next acceptance.
